drp_rmw_arbiter: RTL

- Shares the single GTH channel DRP port between NUM_REQ requesters, e.g. the AXI register bridge and a DMONITOR/eye-scan sequencer.
- Performs plain reads, plain writes and masked read-modify-writes with a proper DRPEN/DRPRDY handshake, and a timeout in case DRPRDY never returns.
- Sits in the free-running DRP clock domain between the requesters and the GTH wizard DRP pins.
- Replaces ad-hoc single-pulse DRPEN generation.

---
 rtl/drp_rmw_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/drp_rmw_arbiter.sv
// drp_rmw_arbiter: round-robin arbiter sharing one GTH DRP port.
// Supports read, write and masked read-modify-write with timeout.
module drp_rmw_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                    drp_clk,
   input  logic                    drp_rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [2*NUM_REQ-1:0]    req_op,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
   input  logic [DATA_W*NUM_REQ-1:0] req_wmask,
   output logic [NUM_REQ-1:0]      req_ack,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    drp_en,
   output logic                    drp_we,
   output logic [ADDR_W-1:0]       drp_addr,
   output logic [DATA_W-1:0]       drp_di,
   input  logic [DATA_W-1:0]       drp_do,
   input  logic                    drp_rdy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = 10;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_MERGE, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       gnt_q, gnt_d;
   logic [IW-1:0]       rr_q, rr_d;
   logic [IW-1:0]       arb_idx;
   logic [IW:0]         arb_j;
   logic                arb_hit;
   logic [1:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   wmask_q, wmask_d;
   logic [DATA_W-1:0]   old_q, old_d;
   logic [DATA_W-1:0]   merge_q, merge_d;
   logic                ph2_q, ph2_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                en_q, en_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   di_q, di_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rerr_q, rerr_d;
   logic                tout;
   logic                is_wr, is_rmw;

   assign is_wr  = (op_q == 2'b01);
   assign is_rmw = (op_q == 2'b10);

   // Round-robin search starting just after the last granted requester
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      arb_j   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         arb_j = {1'b0, rr_q} + (IW+1)'(i);
         if (arb_j >= (IW+1)'(NUM_REQ))
            arb_j = arb_j - (IW+1)'(NUM_REQ);
         if (!arb_hit && req_valid[arb_j[IW-1:0]]) begin
            arb_hit = 1'b1;
            arb_idx = arb_j[IW-1:0];
         end
      end
   end

   // Next-state and registered-output computation for the access FSM
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      old_d   = old_q;
      merge_d = merge_q;
      ph2_d   = ph2_q;
      cnt_d   = cnt_q;
      en_d    = 1'b0;
      we_d    = 1'b0;
      di_d    = di_q;
      ack_d   = '0;
      rdata_d = rdata_q;
      rerr_d  = rerr_q;
      tout    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (arb_hit) begin
               gnt_d   = arb_idx;
               op_d    = req_op[2*int'(arb_idx) +: 2];
               addr_d  = req_addr[ADDR_W*int'(arb_idx) +: ADDR_W];
               wdata_d = req_wdata[DATA_W*int'(arb_idx) +: DATA_W];
               wmask_d = req_wmask[DATA_W*int'(arb_idx) +: DATA_W];
               old_d   = '0;
               ph2_d   = 1'b0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            en_d    = 1'b1;
            we_d    = is_wr | ph2_q;
            di_d    = ph2_q ? merge_q : (is_wr ? wdata_q : '0);
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (drp_rdy) begin
               if (!is_wr && !ph2_q)
                  old_d = drp_do;
               state_d = (is_rmw && !ph2_q) ? S_MERGE : S_DONE;
            end else if (cnt_d == CW'(TIMEOUT)) begin
               tout    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_MERGE: begin
            merge_d = (old_q & ~wmask_q) | (wdata_q & wmask_q);
            ph2_d   = 1'b1;
            state_d = (merge_d == old_q) ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            rr_d    = (gnt_q == IW'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_DONE && state_q != S_DONE) begin
         ack_d[gnt_q] = 1'b1;
         rdata_d      = is_wr ? '0 : old_d;
         rerr_d       = tout;
      end
   end

   // State and output registers, all cleared by async reset
   always_ff @(posedge drp_clk or negedge drp_rst_n) begin
      if (!drp_rst_n) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         old_q   <= '0;
         merge_q <= '0;
         ph2_q   <= 1'b0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         di_q    <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         old_q   <= old_d;
         merge_q <= merge_d;
         ph2_q   <= ph2_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         we_q    <= we_d;
         di_q    <= di_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   assign req_ack   = ack_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = rerr_q;
   assign busy      = (state_q != S_IDLE);
   assign drp_en    = en_q;
   assign drp_we    = we_q;
   assign drp_addr  = addr_q;
   assign drp_di    = di_q;

endmodule
